// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Accepts framed bytes (SYNC_BYTE, length L, 4*L little-endian data bytes,
// XOR checksum). Each completed word is written to sequential word addresses.
// The core is held in reset until a frame passes its checksum.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   rx_data/rx_valid    incoming byte stream
//   rx_ready            byte accepted when rx_valid && rx_ready (state decode)
//   start               re-arms the loader from DONE or ERR
//   wr_en/addr/data     registered instruction-memory write port
//   cpu_rst             holds the core in reset while high
//   done / err          frame accepted / rejected
//   words_loaded        words written in the current frame
module imem_loader #(
    parameter int unsigned WORDS     = 64,
    parameter int unsigned ADDR_W    = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  len_q,     len_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [1:0]        lane_q,    lane_d;
    logic [23:0]       asm_q,     asm_d;
    logic [7:0]        xor_q,     xor_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;

    // Ready is a pure decode of the state: only the terminal states refuse bytes.
    assign rx_ready = !(state_q == S_DONE || state_q == S_ERR);
    assign accept   = rx_valid && rx_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        asm_d     = asm_q;
        xor_d     = xor_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            S_SYNC: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                    lane_d  = '0;
                    xor_d   = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (rx_data != 8'd0 && 32'(rx_data) <= WORDS) begin
                        len_d   = CNT_W'(rx_data);
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d  = xor_q ^ rx_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd0) begin
                        asm_d[7:0] = rx_data;
                    end else if (lane_q == 2'd1) begin
                        asm_d[15:8] = rx_data;
                    end else if (lane_q == 2'd2) begin
                        asm_d[23:16] = rx_data;
                    end else begin
                        // Lane 3 completes the word; write it straight from the input.
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[ADDR_W-1:0];
                        wr_data_d = {rx_data, asm_q};
                        cnt_d     = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == xor_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_SYNC;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_SYNC;
            len_q     <= '0;
            cnt_q     <= '0;
            lane_q    <= '0;
            asm_q     <= '0;
            xor_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            asm_q     <= asm_d;
            xor_q     <= xor_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames with random payloads, compared
// against a frame-level reference model of the loader.
module tb_imem_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [37:0] wq_t[$];

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        start;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [6:0]  words_loaded;

    int   checks = 0;
    int   errors = 0;
    wq_t  got;
    bq_t  fr;
    bq_t  garbage;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .start        (start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every write pulse, one entry per cycle wr_en is high.
    always @(negedge clk) begin
        if (wr_en === 1'b1) got.push_back({wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: expected writes and outcome (0 incomplete, 1 done, 2 err).
    function automatic void model(input bq_t b, output wq_t exp, output int outcome);
        int i = 0;
        int len;
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        exp = {};
        outcome = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i >= b.size()) return;
        i++;
        if (i >= b.size()) return;
        len = int'(b[i]);
        i++;
        if (len == 0 || len > 64) begin
            outcome = 2;
            return;
        end
        for (int k = 0; k < len; k++) begin
            if (i + 4 > b.size()) return;
            w = {b[i+3], b[i+2], b[i+1], b[i]};
            x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
            exp.push_back({6'(k), w});
            i += 4;
        end
        if (i >= b.size()) return;
        outcome = (b[i] == x) ? 1 : 2;
    endfunction

    function automatic bq_t make_frame(input int n, input logic [7:0] flip);
        bq_t f;
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        f.push_back(8'hA5);
        f.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            f.push_back(b);
        end
        f.push_back(x ^ flip);
        return f;
    endfunction

    // Present one byte for one cycle, optionally after random idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic pulse);
        int idle = 0;
        while (gap > 0 && idle < 3 && int'($urandom_range(99)) < gap) begin
            @(negedge clk);
            idle++;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = pulse;
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_frame(input bq_t b, input int gap, input int start_at);
        for (int i = 0; i < b.size(); i++) send_byte(b[i], gap, (i == start_at));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Compare terminal flags right after the last byte, then all writes.
    task automatic finish_frame(input bq_t b, input string tag);
        wq_t exp;
        int  outcome;
        model(b, exp, outcome);
        check({tag, "_done"},    64'(done),     64'(outcome == 1));
        check({tag, "_err"},     64'(err),      64'(outcome == 2));
        check({tag, "_cpu_rst"}, 64'(cpu_rst),  64'(outcome != 1));
        check({tag, "_rx_ready"},64'(rx_ready), 64'(outcome == 0));
        check({tag, "_words"},   64'(words_loaded), 64'(exp.size()));
        repeat (2) @(negedge clk);
        check({tag, "_nwr"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_wr%0d", tag, i), 64'(got[i]), 64'(exp[i]));
        end
        got.delete();
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'd1);
        check("rst_wr_en",    64'(wr_en),    64'd0);
        check("rst_wr_addr",  64'(wr_addr),  64'd0);
        check("rst_wr_data",  64'(wr_data),  64'd0);
        check("rst_cpu_rst",  64'(cpu_rst),  64'd1);
        check("rst_done",     64'(done),     64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_words",    64'(words_loaded), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // One-word frame with exact write timing.
        fr = {8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        for (int i = 0; i < 6; i++) send_byte(fr[i], 0, 1'b0);
        check("one_wr_en",   64'(wr_en),   64'd1);
        check("one_wr_addr", 64'(wr_addr), 64'd0);
        check("one_wr_data", 64'(wr_data), 64'h13);
        check("one_words",   64'(words_loaded), 64'd1);
        check("one_early_done", 64'(done), 64'd0);
        send_byte(fr[6], 0, 1'b0);
        check("one_wr_en_clear", 64'(wr_en), 64'd0);
        finish_frame(fr, "one");
        pulse_start();
        check("rearm_done",     64'(done),     64'd0);
        check("rearm_cpu_rst",  64'(cpu_rst),  64'd1);
        check("rearm_words",    64'(words_loaded), 64'd0);
        check("rearm_rx_ready", 64'(rx_ready), 64'd1);

        // Full-depth frame, back-to-back bytes.
        fr = make_frame(64, 8'h00);
        send_frame(fr, 0, -1);
        finish_frame(fr, "full");
        pulse_start();

        // Bad checksum: words written, then rejected.
        fr = make_frame(3, 8'h01);
        send_frame(fr, 0, -1);
        finish_frame(fr, "badcs");
        pulse_start();
        check("badcs_rearm_err",      64'(err),      64'd0);
        check("badcs_rearm_rx_ready", 64'(rx_ready), 64'd1);

        // Illegal lengths.
        fr = {8'hA5, 8'h00};
        send_frame(fr, 0, -1);
        finish_frame(fr, "len0");
        pulse_start();
        fr = {8'hA5, 8'd65};
        send_frame(fr, 0, -1);
        finish_frame(fr, "len65");
        pulse_start();

        // Garbage prefix, random gaps, start pulsed mid-frame.
        garbage = {8'h00, 8'hFF, 8'h5A};
        fr = make_frame(5, 8'h00);
        fr = {garbage, fr};
        send_frame(fr, 40, 9);
        finish_frame(fr, "gaps");
        pulse_start();

        // Reset after two of three words, then a fresh frame.
        fr = make_frame(3, 8'h00);
        for (int i = 0; i < 10; i++) send_byte(fr[i], 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rx_ready", 64'(rx_ready), 64'd1);
        check("abort_cpu_rst",  64'(cpu_rst),  64'd1);
        check("abort_words",    64'(words_loaded), 64'd0);
        check("abort_done",     64'(done),     64'd0);
        check("abort_nwr",      64'(got.size()), 64'd2);
        got.delete();
        fr = make_frame(2, 8'h00);
        send_frame(fr, 0, -1);
        finish_frame(fr, "fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
